// File: rtl/bitstream_pkg.sv
// Shared constants and FSM state type for the bitstream_p emulation-prevention filter.
package bitstream_pkg;

  localparam logic [7:0] BYTE_ZERO = 8'h00;
  localparam logic [7:0] BYTE_EP   = 8'h03;
  localparam logic [7:0] BYTE_SC   = 8'h01;

  typedef enum logic {
    S_SCAN  = 1'b0,
    S_FLUSH = 1'b1
  } state_t;

endpackage

// File: rtl/bs_word_unpack.sv
// One-word stream buffer that presents its bytes MSB first through a one-byte slot.
module bs_word_unpack #(
  parameter int unsigned DATA_BITS = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 consume,
  output logic [7:0]           cur_byte,
  output logic                 cur_vld
);

  localparam int unsigned NB    = DATA_BITS / 8;
  localparam int unsigned IDX_W = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB - 1);

  logic [DATA_BITS-1:0] word;
  logic                 full;
  logic [IDX_W-1:0]     byte_idx;
  logic                 armed;
  logic [7:0]           sel_byte;
  logic                 take;
  logic                 last;
  logic                 accept;

  always_comb begin
    sel_byte = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      if (byte_idx == IDX_W'(i)) sel_byte = word[DATA_BITS-1-8*i -: 8];
    end
  end

  // The slot gives the classifier a registered byte; the buffer refills it
  // in the same cycle it is consumed, so throughput stays at one byte/cycle.
  assign take     = full && (!cur_vld || consume);
  assign last     = (byte_idx == LAST_IDX);
  assign in_ready = armed && (!full || (take && last));
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed    <= 1'b0;
      word     <= '0;
      full     <= 1'b0;
      byte_idx <= '0;
      cur_byte <= '0;
      cur_vld  <= 1'b0;
    end else begin
      armed <= 1'b1;
      if (accept) begin
        word     <= in_data;
        full     <= 1'b1;
        byte_idx <= '0;
      end else if (take && last) begin
        full     <= 1'b0;
        byte_idx <= '0;
      end else if (take) begin
        byte_idx <= byte_idx + IDX_W'(1);
      end
      if (take) begin
        cur_byte <= sel_byte;
        cur_vld  <= 1'b1;
      end else if (consume) begin
        cur_vld <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/bitstream_ep_filter.sv
// Annex-B start-code detector and emulation-prevention byte remover feeding the bit reader.
module bitstream_ep_filter
  import bitstream_pkg::*;
#(
  parameter int unsigned DATA_BITS = 32,
  parameter int unsigned CNT_BITS  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [7:0]           out_byte,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_first,
  output logic                 start_code,
  output logic [CNT_BITS-1:0]  ep_cnt
);

  logic [7:0] cur_byte;
  logic       cur_vld;
  logic       consume;

  bs_word_unpack #(
    .DATA_BITS (DATA_BITS)
  ) u_unpack (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .consume  (consume),
    .cur_byte (cur_byte),
    .cur_vld  (cur_vld)
  );

  state_t     state, nstate;
  logic [1:0] zero_pend, nzero_pend;
  logic       first_pend, nfirst_pend;
  logic       hold_vld, nhold_vld;
  logic [7:0] hold_byte, nhold_byte;
  logic       can_emit;
  logic       emit;
  logic [7:0] emit_byte;
  logic       ep_inc;
  logic       sc_pulse;

  assign can_emit   = !out_valid || out_ready;
  assign start_code = sc_pulse;

  always_comb begin
    nstate      = state;
    nzero_pend  = zero_pend;
    nfirst_pend = first_pend;
    nhold_vld   = hold_vld;
    nhold_byte  = hold_byte;
    consume     = 1'b0;
    emit        = 1'b0;
    emit_byte   = '0;
    ep_inc      = 1'b0;
    sc_pulse    = 1'b0;
    if (can_emit) begin
      unique case (state)
        S_SCAN: begin
          if (cur_vld) begin
            consume = 1'b1;
            if (cur_byte == BYTE_ZERO) begin
              // A third zero pushes the oldest one out as prefix/trailing padding.
              if (zero_pend != 2'd2) nzero_pend = zero_pend + 2'd1;
            end else if (cur_byte == BYTE_EP && zero_pend == 2'd2) begin
              ep_inc    = 1'b1;
              nstate    = S_FLUSH;
              nhold_vld = 1'b0;
            end else if (cur_byte == BYTE_SC && zero_pend == 2'd2) begin
              sc_pulse    = 1'b1;
              nzero_pend  = 2'd0;
              nfirst_pend = 1'b1;
            end else if (zero_pend == 2'd0) begin
              emit        = 1'b1;
              emit_byte   = cur_byte;
              nfirst_pend = 1'b0;
            end else begin
              nstate     = S_FLUSH;
              nhold_vld  = 1'b1;
              nhold_byte = cur_byte;
            end
          end
        end
        S_FLUSH: begin
          if (zero_pend != 2'd0) begin
            emit        = 1'b1;
            emit_byte   = BYTE_ZERO;
            nfirst_pend = 1'b0;
            nzero_pend  = zero_pend - 2'd1;
            if (zero_pend == 2'd1 && !hold_vld) nstate = S_SCAN;
          end else begin
            if (hold_vld) begin
              emit        = 1'b1;
              emit_byte   = hold_byte;
              nfirst_pend = 1'b0;
              nhold_vld   = 1'b0;
            end
            nstate = S_SCAN;
          end
        end
        default: nstate = S_SCAN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_SCAN;
      zero_pend  <= '0;
      first_pend <= 1'b0;
      hold_vld   <= 1'b0;
      hold_byte  <= '0;
      out_byte   <= '0;
      out_valid  <= 1'b0;
      out_first  <= 1'b0;
      ep_cnt     <= '0;
    end else if (can_emit) begin
      state      <= nstate;
      zero_pend  <= nzero_pend;
      first_pend <= nfirst_pend;
      hold_vld   <= nhold_vld;
      hold_byte  <= nhold_byte;
      if (emit) begin
        out_valid <= 1'b1;
        out_byte  <= emit_byte;
        out_first <= first_pend;
      end else begin
        out_valid <= 1'b0;
        out_first <= 1'b0;
      end
      if (ep_inc && ep_cnt != '1) ep_cnt <= ep_cnt + CNT_BITS'(1);
    end
  end

endmodule
